// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-lane valid/ready merge into one registered output; define ARB_MUX_RR_EN for round-robin, otherwise fixed lowest-index priority
module arb_mux #(
    parameter int S = 2,
    parameter int T = 8,
    localparam int N = 2 ** S
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*T-1:0] in,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [T-1:0]   out,
    output logic [S-1:0]   out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [T-1:0] lane [N];
    logic [S-1:0] ptr;
    logic [S-1:0] scan;
    logic [S-1:0] grant;
    logic         found;
    logic         load;
    logic         xfer;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_lane
            assign lane[k] = in[k*T +: T];
        end
    endgenerate

    // Search starts at ptr and wraps through the S-bit index naturally.
    always_comb begin
        found = 1'b0;
        grant = '0;
        scan  = '0;
        for (int i = 0; i < N; i++) begin
            scan = ptr + S'(i);
            if (!found && in_valid[scan]) begin
                found = 1'b1;
                grant = scan;
            end
        end
    end

    assign load = !out_valid || out_ready;
    assign xfer = load && found;

    // in_ready is gated by rst_n so nothing handshakes while reset is held.
    assign in_ready = (rst_n && xfer) ? (N'(1) << grant) : '0;

`ifdef ARB_MUX_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= grant + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out     <= lane[grant];
                out_sel <= grant;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - randomized and directed checks of arb_mux against a behavioural lane-priority model
module tb_arb_mux;

    localparam int S = 2;
    localparam int T = 8;
    localparam int N = 4;

`ifdef ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N*T-1:0] in;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [T-1:0]   out;
    logic [S-1:0]   out_sel;
    logic           out_valid;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    int       m_ptr;
    bit       m_ov;
    int       m_out;
    int       m_sel;

    arb_mux #(.S(S), .T(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int j = 0; j < N; j++) begin
            if (v[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_ov  = 1'b0;
        m_out = 0;
        m_sel = 0;
    endtask

    // Called just after a rising edge; applies inputs and checks through the next edge.
    task automatic cycle(input logic [N*T-1:0] d, input logic [N-1:0] v, input logic r);
        bit ld;
        int g;
        int exp_rdy;
        in        = d;
        in_valid  = v;
        out_ready = r;
        ld = !m_ov || r;
        g  = pick(v, RR ? m_ptr : 0);
        exp_rdy = (ld && g >= 0) ? (1 << g) : 0;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (ld) begin
            if (g >= 0) begin
                m_ov  = 1'b1;
                m_out = int'(d[g*T +: T]);
                m_sel = g;
                m_ptr = (g + 1) % N;
            end else begin
                m_ov = 1'b0;
            end
        end
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out", 32'(out), 32'(m_out));
        check("out_sel", 32'(out_sel), 32'(m_sel));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N*T-1:0] pat;
        rst_n     = 1'b0;
        in        = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        in_valid = 4'b1111;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        @(posedge clk);
        #1;
        in_valid = '0;
        rst_n = 1'b1;

        repeat (10) cycle($urandom, 4'b0000, $urandom_range(0, 1));

        pat = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            cycle(pat, 4'b1111, 1'b1);
            check("seq_sel", 32'(out_sel), RR ? 32'(i % 4) : 32'h0);
            check("seq_out", 32'(out), RR ? 32'(8'h11 * ((i % 4) + 1)) : 32'h11);
        end

        do_reset();
        cycle(pat, 4'b0010, 1'b0);
        check("hold_load", 32'(out), 32'h22);
        for (int i = 0; i < 5; i++) begin
            cycle($urandom, 4'b1111, 1'b0);
            check("hold_sel", 32'(out_sel), 32'h1);
        end
        cycle(pat, 4'b1111, 1'b1);
        check("release_sel", 32'(out_sel), RR ? 32'h2 : 32'h0);

        do_reset();
        cycle(pat, 4'b1000, 1'b1);
        check("wrap_sel3", 32'(out_sel), 32'h3);
        cycle(pat, 4'b0001, 1'b1);
        check("wrap_sel0", 32'(out_sel), 32'h0);

        cycle(pat, 4'b0100, 1'b0);
        cycle(pat, 4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_in_ready", 32'(in_ready), 32'h0);
        check("async_out", 32'(out), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(pat, 4'b1111, 1'b1);
        check("post_rst_sel", 32'(out_sel), 32'h0);

        for (int i = 0; i < 300; i++) begin
            cycle({$urandom}, 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter S, default 2, lane-select width; lane count N = 2**S.
REQ-002 Parameter T, default 8, data width per lane.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  N*T  packed lane data; lane k occupies bits [k*T+T-1 : k*T].
REQ-006 in_valid  input  N  per-lane valid; bit k qualifies lane k.
REQ-007 in_ready  output  N  per-lane ready; transfer on lane k when in_valid[k] and in_ready[k] are both high at a clock edge.
REQ-008 out  output  T  registered merged data.
REQ-009 out_sel  output  S  registered index of the lane that supplied out.
REQ-010 out_valid  output  1  registered; out and out_sel hold valid data.
REQ-011 out_ready  input  1  downstream accepts out when out_valid and out_ready are high at a clock edge.

Function
REQ-012 Block SHALL merge N lanes into one stream through a single output register stage; it is the gathering counterpart of a 2**S-way demux using the same packed lane layout.
REQ-013 Load enable: load = !out_valid | out_ready.
REQ-014 Grant SHALL be computed combinationally from in_valid and the priority pointer; at most one bit of in_ready high in any cycle.
REQ-015 in_ready[g] SHALL be high only when load is high and lane g is the granted lane; all other bits low.
REQ-016 If no in_valid bit is high, in_ready SHALL be all zero and no lane is granted.
REQ-017 On a transfer from lane g: out <= lane g data, out_sel <= g, out_valid <= 1 at the same edge; latency from accepted input to out_valid is 1 cycle.
REQ-018 If load is high, no lane is valid, and out_valid was high with out_ready high, out_valid SHALL drop to 0 at that edge.
REQ-019 While out_valid is high and out_ready is low, out, out_sel and out_valid SHALL hold; in_ready all zero (back-pressure).
REQ-020 Simultaneous drain and fill (out_valid, out_ready, new grant in one cycle) SHALL sustain one transfer per cycle with no bubble.
REQ-021 Priority pointer ptr (S bits) SHALL search lanes ptr, ptr+1, ... modulo N; first valid lane wins.
REQ-022 After a transfer from lane g, ptr <= (g+1) mod N (wraps from N-1 to 0); ptr unchanged in cycles without a transfer.
REQ-023 Input data SHALL NOT be required stable before its handshake; only the value at the transfer edge is captured.

Reset
REQ-024 While rst_n is low: out_valid = 0, out = 0, out_sel = 0, ptr = 0, in_ready forced all zero.
REQ-025 Reset asserted mid-transfer SHALL discard the held output word immediately (asynchronous) with no partial update.
REQ-026 First edge after rst_n rises SHALL already accept a transfer if a lane is valid.

Configuration
REQ-027 Macro ARB_MUX_RR_EN defined: round-robin per REQ-021/022.
REQ-028 ARB_MUX_RR_EN undefined: fixed priority, lowest valid lane index wins every cycle; ptr not implemented (effectively constant 0).

Verification (S=2, T=8)
REQ-029 Reset then all in_valid=0 -> out_valid=0, out=0, out_sel=0, in_ready=4'b0000 for 10 cycles.
REQ-030 in lanes = {8'h44,8'h33,8'h22,8'h11}, in_valid=4'b1111, out_ready=1, RR enabled -> out_sel sequence 0,1,2,3,0 with out 11,22,33,44,11 on consecutive cycles, one-cycle latency, no bubbles.
REQ-031 Same stimulus, ARB_MUX_RR_EN undefined -> out_sel=0, out=8'h11 every cycle; in_ready=4'b0001.
REQ-032 out_valid=1 (out=8'h22, out_sel=1), out_ready=0 for 5 cycles with in_valid=4'b1111 -> out, out_sel stable, in_ready=4'b0000; out_ready=1 next cycle -> out_sel=2.
REQ-033 in_valid=4'b1000 only, ptr=0 -> lane 3 granted, out_sel=3, ptr wraps to 0; next in_valid=4'b0001 -> out_sel=0.
REQ-034 rst_n pulled low while out_valid=1, out_ready=0 -> out_valid=0 and in_ready=0 immediately without a clock edge; after release ptr restarts at 0.
